// File: rtl/ts_packet_buffer_if.sv
// Byte-stream ingress and packet-drain signals of one TS packet buffer.
// master drives the TS stream and RD_REQ; slave is the buffer itself.
interface ts_packet_buffer_if #(
   parameter int CNT_W = 4
);
   logic [7:0]       TS_DATA;
   logic             TS_VALID;
   logic             TS_PSYNC;
   logic             RD_REQ;
   logic [7:0]       DATA_OUT;
   logic             GOT_FULL_PACKET;
   logic [CNT_W-1:0] PKT_COUNT;
   logic [7:0]       DROP_COUNT;
   logic             SYNC_ERR;

   modport master (
      output TS_DATA, TS_VALID, TS_PSYNC, RD_REQ,
      input  DATA_OUT, GOT_FULL_PACKET, PKT_COUNT, DROP_COUNT, SYNC_ERR
   );

   modport slave (
      input  TS_DATA, TS_VALID, TS_PSYNC, RD_REQ,
      output DATA_OUT, GOT_FULL_PACKET, PKT_COUNT, DROP_COUNT, SYNC_ERR
   );
endinterface

// File: rtl/ts_packet_buffer.sv
// Sync-aligned TS packet store: only whole 188-byte packets become visible to the show-ahead reader.
// Head byte is registered one cycle after a pop; a packet without room for all its bytes is dropped at its sync byte.
module ts_packet_buffer #(
   parameter int PKT_LEN = 188,
   parameter int ADDR_W  = 10,
   parameter int CNT_W   = 4
) (
   input logic               SYS_CLK,
   input logic               RST,
   ts_packet_buffer_if.slave bus
);
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int PW     = ADDR_W + 1;
   localparam int WCNT_W = $clog2(PKT_LEN + 1);

   typedef logic [PW-1:0] ptr_t;
   typedef enum logic [1:0] {HUNT, FILL, SKIP} wstate_t;

   localparam ptr_t              PTR_ONE   = ptr_t'(1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PKT_LEN - 1);
   localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
   localparam logic [PW:0]       DEPTH_W   = (PW + 1)'(DEPTH);
   localparam logic [PW:0]       PKT_LEN_W = (PW + 1)'(PKT_LEN);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   logic [7:0]        mem_q [DEPTH];
   wstate_t           state_q, state_d;
   ptr_t              wr_ptr_q, wr_ptr_d;
   ptr_t              commit_q, commit_d;
   ptr_t              rd_ptr_q, rd_ptr_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [WCNT_W-1:0] rcnt_q, rcnt_d;
   logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
   logic [7:0]        drop_q, drop_d;
   logic              sync_err_q, sync_err_d;
   logic              got_full_q;
   logic [7:0]        data_out_q;

   logic              mem_we;
   ptr_t              mem_waddr;
   logic              commit_evt;
   logic              pop;
   logic              rd_last;
   logic [PW:0]       free_w;

   // Free space is judged against committed data only; any partial packet is rewound before a new start.
   assign free_w = DEPTH_W - {1'b0, ptr_t'(commit_q - rd_ptr_q)};

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      commit_d   = commit_q;
      wcnt_d     = wcnt_q;
      drop_d     = drop_q;
      sync_err_d = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = wr_ptr_q;
      commit_evt = 1'b0;
      if (bus.TS_VALID) begin
         if (bus.TS_PSYNC) begin
            wr_ptr_d = commit_q;
            wcnt_d   = '0;
            if (state_q == FILL) sync_err_d = 1'b1;
            if (bus.TS_DATA != 8'h47) begin
               sync_err_d = 1'b1;
               state_d    = HUNT;
            end else if (free_w >= PKT_LEN_W) begin
               mem_we    = 1'b1;
               mem_waddr = commit_q;
               wr_ptr_d  = commit_q + PTR_ONE;
               wcnt_d    = WCNT_ONE;
               state_d   = FILL;
            end else begin
               if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
               state_d = SKIP;
            end
         end else if (state_q == FILL) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            wcnt_d   = wcnt_q + WCNT_ONE;
            if (wcnt_q == WCNT_LAST) begin
               commit_d   = wr_ptr_q + PTR_ONE;
               commit_evt = 1'b1;
               wcnt_d     = '0;
               state_d    = HUNT;
            end
         end
      end
   end

   always_comb begin
      pop      = bus.RD_REQ && (pkt_count_q != '0);
      rd_last  = pop && (rcnt_q == WCNT_LAST);
      rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      rcnt_d   = rcnt_q;
      if (rd_last)  rcnt_d = '0;
      else if (pop) rcnt_d = rcnt_q + WCNT_ONE;
      pkt_count_d = pkt_count_q;
      if (commit_evt && !rd_last)      pkt_count_d = pkt_count_q + CNT_ONE;
      else if (!commit_evt && rd_last) pkt_count_d = pkt_count_q - CNT_ONE;
   end

   always_ff @(posedge SYS_CLK) begin
      if (mem_we) mem_q[mem_waddr[ADDR_W-1:0]] <= bus.TS_DATA;
   end

   // Reading at the next pointer keeps DATA_OUT equal to mem[rd_ptr] one cycle after every pop.
   always_ff @(posedge SYS_CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= HUNT;
         wr_ptr_q    <= '0;
         commit_q    <= '0;
         rd_ptr_q    <= '0;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         pkt_count_q <= '0;
         drop_q      <= '0;
         sync_err_q  <= 1'b0;
         got_full_q  <= 1'b0;
         data_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         commit_q    <= commit_d;
         rd_ptr_q    <= rd_ptr_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         pkt_count_q <= pkt_count_d;
         drop_q      <= drop_d;
         sync_err_q  <= sync_err_d;
         got_full_q  <= (pkt_count_d != '0);
         data_out_q  <= mem_q[rd_ptr_d[ADDR_W-1:0]];
      end
   end

   assign bus.DATA_OUT        = data_out_q;
   assign bus.GOT_FULL_PACKET = got_full_q;
   assign bus.PKT_COUNT       = pkt_count_q;
   assign bus.DROP_COUNT      = drop_q;
   assign bus.SYNC_ERR        = sync_err_q;
endmodule
